// File: rtl/dir_pulser.sv
// Key conditioner: synchronise, debounce and one-shot four active-low buttons into a one-hot
// valid/ready direction request. Optional auto-repeat of a held key via the KEY_REPEAT_EN macro.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RELEASE | wait for all keys released (debounced and synchronised)
// ARMED   | ready to issue the next single-key press
// ISSUE   | request pending, held until dir_valid && dir_ready
module dir_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [3:0] direction,
  output logic       multi_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    ARMED   = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prime_q;
  logic             dir_valid_q;
  logic [3:0]       direction_q;
  logic             multi_key_q;
  logic             stable_multi;
  logic             stable_onehot;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= ~key_n;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // One counter shared by all four keys; any return to the stable value restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_multi  = (stable_q & (stable_q - 4'd1)) != 4'd0;
  assign stable_onehot = (stable_q != 4'd0) && !stable_multi;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q;
  logic [3:0]       last_dir_q;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RELEASE;
      dir_valid_q <= 1'b0;
      direction_q <= '0;
      multi_key_q <= 1'b0;
      prime_q     <= '0;
`ifdef KEY_REPEAT_EN
      rep_q       <= '0;
      last_dir_q  <= '0;
`endif
    end else begin
      multi_key_q <= stable_multi;
      prime_q     <= {prime_q[0], 1'b1};
`ifdef KEY_REPEAT_EN
      rep_q       <= '0;
`endif
      case (state_q)
        RELEASE: begin
          // prime_q keeps a key held through reset from looking released while the
          // synchroniser still holds its reset value.
          if (prime_q[1] && (stable_q == 4'd0) && (s2_q == 4'd0)) begin
            state_q <= ARMED;
          end
`ifdef KEY_REPEAT_EN
          else if ((last_dir_q != 4'd0) && (stable_q == last_dir_q)) begin
            if (rep_q == REP_MAX) begin
              dir_valid_q <= 1'b1;
              direction_q <= last_dir_q;
              state_q     <= ISSUE;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
          end
`endif
        end
        ARMED: begin
          if (stable_onehot) begin
            dir_valid_q <= 1'b1;
            direction_q <= stable_q;
            state_q     <= ISSUE;
          end else if (stable_multi) begin
            state_q <= RELEASE;
          end
        end
        ISSUE: begin
          if (dir_ready) begin
            dir_valid_q <= 1'b0;
            direction_q <= '0;
            state_q     <= RELEASE;
`ifdef KEY_REPEAT_EN
            last_dir_q  <= direction_q;
`endif
          end
        end
        default: begin
          dir_valid_q <= 1'b0;
          direction_q <= '0;
          state_q     <= RELEASE;
        end
      endcase
    end
  end

  assign dir_valid = dir_valid_q;
  assign direction = direction_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_dir_pulser.sv
// Directed bench for dir_pulser with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_dir_pulser;

  localparam int D = 4;
  localparam int R = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       dir_ready;
  logic       dir_valid;
  logic [3:0] direction;
  logic       multi_key;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dir_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clock    (clock),
    .reset    (reset),
    .key_n    (key_n),
    .dir_ready(dir_ready),
    .dir_valid(dir_valid),
    .direction(direction),
    .multi_key(multi_key)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs n cycles; reports how many had dir_valid, the first such cycle and its direction.
  task automatic run(input int n, output int cnt, output int first, output logic [3:0] fdir);
    cnt = 0; first = -1; fdir = '0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (dir_valid === 1'b1) begin
        cnt++;
        if (first < 0) begin first = i; fdir = direction; end
      end
    end
  endtask

  int         cnt, first, bad;
  logic [3:0] fdir;

  initial begin
    reset = 1'b1; key_n = 4'hF; dir_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(dir_valid), 0);
    chk("rst_dir",   32'(direction), 0);
    chk("rst_multi", 32'(multi_key), 0);
    reset = 1'b0;
    run(10, cnt, first, fdir);
    chk("idle_cnt", cnt, 0);

    // clean press of up
    key_n = 4'b0111;
    run(7, cnt, first, fdir);
    chk("up_first", first, 7);
    chk("up_dir",   32'(fdir), 32'(4'b1000));
    tick();
    chk("up_one_cycle", 32'(dir_valid), 0);
    chk("up_dir_clr",   32'(direction), 0);
    run(15, cnt, first, fdir);
    chk("up_held_cnt", cnt, 0);
    key_n = 4'hF;
    run(15, cnt, first, fdir);
    chk("up_release_cnt", cnt, 0);

    // bounce on left, never stable long enough
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      key_n = ((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111;
      tick();
      if (dir_valid === 1'b1) cnt++;
      if (multi_key === 1'b1) cnt++;
    end
    key_n = 4'hF;
    run(10, first, bad, fdir);
    chk("bounce_cnt", cnt + first, 0);

    // right with controller stalled, then accept
    dir_ready = 1'b0;
    key_n = 4'b1110;
    run(7, cnt, first, fdir);
    chk("right_first", first, 7);
    chk("right_dir",   32'(fdir), 32'(4'b0001));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dir_valid !== 1'b1 || direction !== 4'b0001) bad++;
    end
    chk("right_hold", bad, 0);
    dir_ready = 1'b1;
    tick();
    chk("right_accept", 32'(dir_valid), 0);
    run(10, cnt, first, fdir);
    chk("right_after", cnt, 0);
    key_n = 4'hF;
    run(15, cnt, first, fdir);

    // up+left together is rejected
    key_n = 4'b0101;
    run(7, cnt, first, fdir);
    chk("multi_flag", 32'(multi_key), 1);
    run(10, bad, first, fdir);
    chk("multi_cnt", cnt + bad, 0);
    key_n = 4'hF;
    run(15, cnt, first, fdir);
    chk("multi_clear", 32'(multi_key), 0);
    key_n = 4'b1011;
    run(7, cnt, first, fdir);
    chk("down_first", first, 7);
    chk("down_dir",   32'(fdir), 32'(4'b0100));
    key_n = 4'hF;
    run(15, cnt, first, fdir);

    // left held through reset deassertion
    reset = 1'b1; key_n = 4'b1101;
    repeat (3) tick();
    reset = 1'b0;
    run(25, cnt, first, fdir);
    chk("held_rst_cnt", cnt, 0);
    key_n = 4'hF;
    run(15, cnt, first, fdir);
    chk("held_rel_cnt", cnt, 0);
    dir_ready = 1'b0;
    key_n = 4'b1101;
    run(7, cnt, first, fdir);
    chk("left_first", first, 7);
    chk("left_dir",   32'(fdir), 32'(4'b0010));
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(dir_valid), 0);
    chk("rst_mid_dir",   32'(direction), 0);
    key_n = 4'hF; dir_ready = 1'b1;
    tick();
    reset = 1'b0;
    run(15, cnt, first, fdir);
    chk("post_rst_cnt", cnt, 0);

`ifdef KEY_REPEAT_EN
    // held down auto-repeats every R+1 cycles
    key_n = 4'b1011;
    bad = 0; cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (dir_valid === 1'b1) begin
        if (!(i == 7 || i == 7 + R + 1 || i == 7 + 2 * (R + 1)) || direction !== 4'b0100) bad++;
        cnt++;
      end
    end
    chk("rep_bad", bad, 0);
    chk("rep_cnt", cnt, 3);
    key_n = 4'hF;
    run(40, cnt, first, fdir);
    chk("rep_stop", cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
